// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle sequencer for the RV32 M-extension operations, used in the EX stage.
//   Multiplies form a registered sign-extended 64-bit product. Divides run a
//   32-step restoring divider followed by a sign-fix cycle.
//
// Ports
//   CLK         rising-edge clock
//   RESET       synchronous, active-high
//   start       EX stage holds an M-extension op (level, held while stalled)
//   alu_opcode  01000..01111 = MUL,MULH,MULHU,MULHSU,DIV,DIVU,REM,REMU
//   operand_a   rs1: multiplicand / dividend
//   operand_b   rs2: multiplier / divisor
//   flush       abort the operation in flight, no done pulse
//   stall       freeze IF/ID/EX (combinational from start)
//   busy        FSM is in MUL, DIV or FIX
//   done        one-cycle pulse, result valid
//   result      operation result, held until overwritten by a later op
//
// Build option
//   MULDIV_DIV_FASTPATH_EN: divide-by-zero and signed overflow complete
//   straight from IDLE (done at cycle 1) instead of after the full divide.

module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [4:0]      alu_opcode,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

`ifdef MULDIV_DIV_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state, state_next;
    logic [1:0]      fn_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvs_q;
    logic [4:0]      cnt_q;

    // Returns {hit, value} for divide-by-zero and signed-overflow cases.
    // fn[1] selects remainder, fn[0] selects unsigned.
    function automatic logic [XLEN:0] special_case(input logic [1:0] fn,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic            hit;
        logic [XLEN-1:0] val;
        hit = 1'b0;
        val = '0;
        if (b == '0) begin
            hit = 1'b1;
            val = fn[1] ? a : '1;
        end else if (!fn[0] && a == MIN_INT && b == '1) begin
            hit = 1'b1;
            val = fn[1] ? '0 : MIN_INT;
        end
        return {hit, val};
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + ONE) : v;
    endfunction

    logic            op_valid, op_is_div, fast_hit;
    logic [XLEN:0]   sp_in, sp_q;

    assign op_valid  = (alu_opcode[4:3] == 2'b01);
    assign op_is_div = alu_opcode[2];
    assign sp_in     = special_case(alu_opcode[1:0], operand_a, operand_b);
    assign fast_hit  = FASTPATH && op_is_div && sp_in[XLEN];
    assign sp_q      = special_case(fn_q, a_q, b_q);

    // Multiply: sign-extending to 2*XLEN and keeping the low 2*XLEN bits of the
    // product is identical to the 33x33 signed product.
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        a_ext   = {{XLEN{fn_q[0] & a_q[XLEN-1]}}, a_q};
        b_ext   = {{XLEN{(fn_q == 2'b01) & b_q[XLEN-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (fn_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Restoring divide step. When the trial subtract succeeds the true
    // difference is below the divisor, so XLEN-bit arithmetic is exact.
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, fix_res;
    logic            div_signed;

    always_comb begin
        rem_sh     = {rem_q, quo_q[XLEN-1]};
        ge         = (rem_sh >= {1'b0, dvs_q});
        rem_nx     = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        quo_nx     = {quo_q[XLEN-2:0], ge};
        div_signed = ~fn_q[0];
        if (sp_q[XLEN])
            fix_res = sp_q[XLEN-1:0];
        else if (fn_q[1])
            fix_res = (div_signed && a_q[XLEN-1]) ? (~rem_q + ONE) : rem_q;
        else
            fix_res = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? (~quo_q + ONE) : quo_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && op_valid) begin
                    if (!op_is_div)    state_next = S_MUL;
                    else if (fast_hit) state_next = S_DONE;
                    else               state_next = S_DIV;
                end
            end
            S_MUL: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (cnt_q == 5'd0) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
        stall = (start && op_valid && state == S_IDLE) || busy;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fn_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (start && op_valid) begin
                        fn_q  <= alu_opcode[1:0];
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        rem_q <= '0;
                        quo_q <= magnitude(operand_a, ~alu_opcode[0]);
                        dvs_q <= magnitude(operand_b, ~alu_opcode[0]);
                        if (op_is_div) cnt_q <= 5'd31;
                        if (fast_hit)  result <= sp_in[XLEN-1:0];
                    end
                end
                S_MUL: result <= mul_res;
                S_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
                end
                S_FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer: each issued operation pushes its
//   expected result and completion cycle; a monitor pops on every done pulse.
//   Honours MULDIV_DIV_FASTPATH_EN for the special-case divide latency.

module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, start, flush;
    logic [4:0]  alu_opcode;
    logic [31:0] operand_a, operand_b;
    logic        stall, busy, done;
    logic [31:0] result;

`ifdef MULDIV_DIV_FASTPATH_EN
    localparam int SPL = 1;
`else
    localparam int SPL = 34;
`endif

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .alu_opcode (alu_opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always @(negedge CLK) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_res"}, result, e.res);
                check({e.tag, "_lat"}, cyc - e.t0, e.lat);
            end
        end
    end

    function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd12) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (op == 5'd12 || op == 5'd14) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sbv, ub;
        int          si_a, si_b;
        bit          ovf;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        ub   = longint'({32'd0, b});
        si_a = $signed(a);
        si_b = $signed(b);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        case (op)
            5'd8:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            5'd9:  begin p = sa * sbv;                return p[63:32]; end
            5'd10: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'd11: begin p = sa * ub;                 return p[63:32]; end
            5'd12: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf)        return 32'h8000_0000;
                return 32'(si_a / si_b);
            end
            5'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd14: begin
                if (b == 32'd0) return a;
                if (ovf)        return 32'd0;
                return 32'(si_a % si_b);
            end
            5'd15: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Issues one operation and holds start through the DONE cycle, as the EX
    // stage would; returns at the negedge where done is seen.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        bit stall_ok;
        bit seen;
        @(negedge CLK);
        start      = 1'b1;
        alu_opcode = op;
        operand_a  = a;
        operand_b  = b;
        sb.push_back('{exp_res, cyc, exp_lat, tag});
        #1 check({tag, "_stall0"}, {31'd0, stall}, 32'd1);
        stall_ok = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge CLK);
            if (done === 1'b1)       seen = 1'b1;
            else if (stall !== 1'b1) stall_ok = 1'b0;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_back());
        end else begin
            check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
            check({tag, "_stall_hold"}, {31'd0, stall_ok}, 32'd1);
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b, last_exp;

        RESET      = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        alu_opcode = 5'd0;
        operand_a  = 32'd0;
        operand_b  = 32'd0;
        repeat (2) @(negedge CLK);
        check("rst_stall",  {31'd0, stall}, 32'd0);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_result", result,         32'd0);
        RESET = 1'b0;

        do_op("mulh",    5'd9,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        do_op("mulhsu",  5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        do_op("mulhu",   5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        do_op("mul",     5'd8,  32'd7,         32'd6,         32'd42,        2);
        do_op("div",     5'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem",     5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        do_op("remu",    5'd15, 32'd100,       32'd7,         32'd2,         34);
        do_op("divu0",   5'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, SPL);
        do_op("rem_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPL);
        do_op("div_ovf", 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL);
        do_op("rem0",    5'd14, 32'd12345,     32'd0,         32'd12345,     SPL);

        last_exp = 32'd12345;
        for (int n = 0; n < 10; n++) begin
            op = 5'd8 + 5'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (n == 0) a = 32'h8000_0001;
            last_exp = ref_model(op, a, b);
            do_op("rand", op, a, b, last_exp,
                  (op < 5'd12) ? 2 : (is_special(op, a, b) ? SPL : 34));
        end
        @(negedge CLK);
        start = 1'b0;

        // Flush a divide at cycle 10, restart at cycle 12.
        @(negedge CLK);
        start      = 1'b1;
        alu_opcode = 5'd12;
        operand_a  = 32'd1000;
        operand_b  = 32'd3;
        repeat (10) @(negedge CLK);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy",   {31'd0, busy},  32'd0);
        check("flush_stall",  {31'd0, stall}, 32'd0);
        check("flush_done",   {31'd0, done},  32'd0);
        check("flush_result", result,         last_exp);
        do_op("post_flush", 5'd12, 32'd1000, 32'd3, 32'd333, 34);
        @(negedge CLK);
        start = 1'b0;

        // Reset at cycle 5 of a divide, then a non-M opcode with start high.
        @(negedge CLK);
        start      = 1'b1;
        alu_opcode = 5'd13;
        operand_a  = 32'd50;
        operand_b  = 32'd7;
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        start = 1'b0;
        @(negedge CLK);
        check("mid_rst_stall",  {31'd0, stall}, 32'd0);
        check("mid_rst_busy",   {31'd0, busy},  32'd0);
        check("mid_rst_done",   {31'd0, done},  32'd0);
        check("mid_rst_result", result,         32'd0);
        RESET      = 1'b0;
        start      = 1'b1;
        alu_opcode = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1 check("nonm_stall", {31'd0, stall}, 32'd0);
            check("nonm_busy", {31'd0, busy}, 32'd0);
            @(negedge CLK);
        end
        start = 1'b0;
        repeat (3) @(negedge CLK);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
